dcache_ctrl: RTL
================

# dcache_ctrl

Direct-mapped, write-back data cache controller between the 8-bit CPU load/store port and the block-oriented data memory. It tracks tag, valid and dirty bits for 8 four-byte lines and serves hits with no stall. On a miss it sequences a dirty-line writeback, a block fetch and the line allocation, holding the CPU through BUSYWAIT. The CPU-side port keeps the existing READ/WRITE/BUSYWAIT handshake, so the cache drops in without CPU changes.

## Interface
- NUM_LINES, 8: cache lines. Fixed; index width is 3.
- LINE_BYTES, 4: bytes per line. Fixed; offset width is 2.
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high.
- READ  in  1  CPU load request; held until BUSYWAIT is low at a posedge.
- WRITE  in  1  CPU store request; same rule as READ.
- ADDRESS  in  8  byte address: tag [7:5], index [4:2], offset [1:0].
- WRITEDATA  in  8  store byte.
- READDATA  out  8  load byte; combinational from the array on a hit.
- BUSYWAIT  out  1  stall to the CPU.
- mem_read  out  1  block fetch request.
- mem_write  out  1  block writeback request.
- mem_address  out  6  block address {tag,index}.
- mem_writedata  out  32  writeback line; byte 0 in [7:0].
- mem_readdata  in  32  fetched line; byte 0 in [7:0].
- mem_busywait  in  1  memory busy; the transfer is complete at the first posedge with mem_busywait low after the request.

## Operation
- hit = valid[index] & (tag_array[index] == ADDRESS[7:5]).
- BUSYWAIT = (READ|WRITE) & ~(state==IDLE & hit). It is combinational, so BUSYWAIT rises in the same cycle as the request on a miss.
- If READ and WRITE are both asserted, the request is treated as a WRITE.
- FSM states and transitions:
  - IDLE: hit-read returns READDATA = line[index][offset]; nothing is stored. Hit-write stores WRITEDATA to that byte at the posedge and sets dirty. On a miss with a dirty victim, go to WRITEBACK. On a miss with a clean or invalid victim, go to FETCH.
  - WRITEBACK: mem_write=1, mem_address={victim tag, index}, mem_writedata=line[index]. When the transfer completes, clear dirty and go to FETCH.
  - FETCH: mem_read=1, mem_address=ADDRESS[7:2]. When the transfer completes, latch mem_readdata into a fill register and go to ALLOC.
  - ALLOC: one cycle. Write the fill register, tag, valid=1 and dirty=0 into the line, then go to IDLE. The request then hits in IDLE and completes as a normal hit.
- mem_read and mem_write are never both high. Both are low in IDLE and ALLOC.
- RESET takes effect at the posedge, in any state:
  - state becomes IDLE; all valid and dirty bits clear.
  - mem_read=0 and mem_write=0 in the following cycle; an in-flight memory transfer is abandoned.
  - READDATA=0 while no hit. BUSYWAIT=0 unless a request is present.
- Data-array contents are not cleared by reset.

## Timing
- Read or write hit: 0 stall cycles; the CPU completes at the next posedge.
- Clean miss: FETCH (memory latency L cycles, including the completing edge) + ALLOC 1 + hit 1. BUSYWAIT is high for L+1 cycles.
- Dirty miss: WRITEBACK L + FETCH L + ALLOC 1. BUSYWAIT is high for 2L+1 cycles.
- ADDRESS, WRITEDATA, READ and WRITE must remain stable while BUSYWAIT is high. The controller does not latch them except through the fill register.
- The array's write port is used only in IDLE (write hit) and in ALLOC; the two never occur in the same cycle.

## Structure
- Package dcache_pkg holds:
  - state enum {IDLE, WRITEBACK, FETCH, ALLOC};
  - TAG_W=3, IDX_W=3, OFF_W=2 and the line-width constant;
  - address field-extraction functions.
- Sub-module dcache_array: line storage with tag, valid and dirty bits. It has one write port (full line or single byte) and a combinational read. dcache_ctrl instantiates it and contains the FSM and hit logic.

## Test plan
- Reset, then READ at 0x24 with memory line 32'hDDCCBBAA, L=5 -> BUSYWAIT high 6 cycles, READDATA=8'hAA. A repeat READ at 0x25 -> 0 stalls, READDATA=8'hBB.
- WRITE 8'h5A at 0x26 after that fill -> 0 stalls; dirty[1]=1; mem_write never asserted.
- READ at 0xA4 (same index 1, tag 5) -> WRITEBACK with mem_address=6'h09 and mem_writedata=32'hDD5ABBAA, then FETCH with mem_address=6'h29. BUSYWAIT is high 11 cycles.
- READ and WRITE asserted together on a miss -> treated as a write. After ALLOC, only the addressed byte changes and dirty=1.
- RESET asserted in the middle of FETCH -> next cycle state=IDLE and mem_read=0. A READ of the previous address misses again.
- Writes filling all 8 indices, then reads of every address -> every read hits and returns the written byte. No memory traffic occurs after the fills.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types, field widths and address helpers for the direct-mapped data cache.
package dcache_pkg;

   localparam int TAG_W      = 3;
   localparam int IDX_W      = 3;
   localparam int OFF_W      = 2;
   localparam int NUM_LINES  = 8;
   localparam int LINE_BYTES = 4;
   localparam int LINE_W     = LINE_BYTES * 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      FETCH     = 2'd2,
      ALLOC     = 2'd3
   } state_t;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [7:0] a);
      return a[7:5];
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [7:0] a);
      return a[4:2];
   endfunction

   function automatic logic [OFF_W-1:0] addr_off(input logic [7:0] a);
      return a[1:0];
   endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage: data, tag, valid and dirty per line; one write port (line or byte),
// combinational read of the indexed line.
module dcache_array
   import dcache_pkg::*;
(
   input  logic              CLK,
   input  logic              RESET,
   input  logic [IDX_W-1:0]  i_idx,
   input  logic [OFF_W-1:0]  i_off,
   input  logic              i_line_we,
   input  logic              i_byte_we,
   input  logic              i_clr_dirty,
   input  logic [TAG_W-1:0]  i_tag,
   input  logic [LINE_W-1:0] i_line,
   input  logic [7:0]        i_byte,
   output logic [LINE_W-1:0] o_line,
   output logic [TAG_W-1:0]  o_tag,
   output logic              o_valid,
   output logic              o_dirty
);

   logic [LINE_BYTES-1:0][7:0] r_data [NUM_LINES];
   logic [TAG_W-1:0]           r_tag  [NUM_LINES];
   logic [NUM_LINES-1:0]       r_valid;
   logic [NUM_LINES-1:0]       r_dirty;

   // Data and tags keep their contents across reset; only the status bits clear.
   always_ff @(posedge CLK) begin
      if (i_line_we) begin
         r_data[i_idx] <= i_line;
         r_tag[i_idx]  <= i_tag;
      end else if (i_byte_we) begin
         r_data[i_idx][i_off] <= i_byte;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (i_line_we) begin
         r_valid[i_idx] <= 1'b1;
         r_dirty[i_idx] <= 1'b0;
      end else if (i_byte_we) begin
         r_dirty[i_idx] <= 1'b1;
      end else if (i_clr_dirty) begin
         r_dirty[i_idx] <= 1'b0;
      end
   end

   assign o_line  = r_data[i_idx];
   assign o_tag   = r_tag[i_idx];
   assign o_valid = r_valid[i_idx];
   assign o_dirty = r_dirty[i_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Write-back direct-mapped cache controller: hit detection, CPU stall and the
// writeback / fetch / allocate miss sequence toward block memory.
module dcache_ctrl
   import dcache_pkg::*;
(
   input  logic        CLK,
   input  logic        RESET,
   input  logic        READ,
   input  logic        WRITE,
   input  logic [7:0]  ADDRESS,
   input  logic [7:0]  WRITEDATA,
   output logic [7:0]  READDATA,
   output logic        BUSYWAIT,
   output logic        mem_read,
   output logic        mem_write,
   output logic [5:0]  mem_address,
   output logic [31:0] mem_writedata,
   input  logic [31:0] mem_readdata,
   input  logic        mem_busywait,
   output state_t      o_dbg_state
);

   state_t             r_state;
   logic               r_mem_read;
   logic               r_mem_write;
   logic [LINE_W-1:0]  r_fill;

   logic [TAG_W-1:0]   w_tag;
   logic [IDX_W-1:0]   w_idx;
   logic [OFF_W-1:0]   w_off;
   logic [LINE_W-1:0]  w_line;
   logic [TAG_W-1:0]   w_arr_tag;
   logic               w_valid;
   logic               w_dirty;
   logic               w_hit;
   logic               w_req;
   logic               w_idle_hit;
   logic               w_hit_write;
   logic               w_wb_done;

   assign w_tag = addr_tag(ADDRESS);
   assign w_idx = addr_idx(ADDRESS);
   assign w_off = addr_off(ADDRESS);

   assign w_hit       = w_valid & (w_arr_tag == w_tag);
   assign w_req       = READ | WRITE;
   assign w_idle_hit  = (r_state == IDLE) & w_hit;
   // WRITE wins when both strobes are present, so a combined request stores.
   assign w_hit_write = w_idle_hit & WRITE;
   assign w_wb_done   = (r_state == WRITEBACK) & ~mem_busywait;

   dcache_array u_array (
      .CLK         (CLK),
      .RESET       (RESET),
      .i_idx       (w_idx),
      .i_off       (w_off),
      .i_line_we   (r_state == ALLOC),
      .i_byte_we   (w_hit_write),
      .i_clr_dirty (w_wb_done),
      .i_tag       (w_tag),
      .i_line      (r_fill),
      .i_byte      (WRITEDATA),
      .o_line      (w_line),
      .o_tag       (w_arr_tag),
      .o_valid     (w_valid),
      .o_dirty     (w_dirty)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state     <= IDLE;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req & ~w_hit) begin
                  if (w_valid & w_dirty) begin
                     r_state     <= WRITEBACK;
                     r_mem_write <= 1'b1;
                  end else begin
                     r_state    <= FETCH;
                     r_mem_read <= 1'b1;
                  end
               end
            end
            WRITEBACK: begin
               if (~mem_busywait) begin
                  r_state     <= FETCH;
                  r_mem_write <= 1'b0;
                  r_mem_read  <= 1'b1;
               end
            end
            FETCH: begin
               if (~mem_busywait) begin
                  r_fill     <= mem_readdata;
                  r_state    <= ALLOC;
                  r_mem_read <= 1'b0;
               end
            end
            ALLOC:   r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign BUSYWAIT      = w_req & ~w_idle_hit;
   assign READDATA      = w_hit ? w_line[{w_off, 3'b000} +: 8] : 8'h00;
   assign mem_read      = r_mem_read;
   assign mem_write     = r_mem_write;
   // The victim's block address comes from the stored tag, not the request.
   assign mem_address   = (r_state == WRITEBACK) ? {w_arr_tag, w_idx} : ADDRESS[7:2];
   assign mem_writedata = w_line;
   assign o_dbg_state   = r_state;

endmodule
